// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and state encoding for the 4-to-2 encoder
package enc_pkg;

  localparam bit ENC_FIXED = 1'b0;
  localparam bit ENC_RR    = 1'b1;

  localparam int ENC_N = 4;
  localparam int ENC_W = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } enc_state_e;

endpackage

// File: rtl/pri_sel4.sv
// rtl/pri_sel4.sv - combinational 4-way priority select, fixed (high index wins) or rotating
module pri_sel4
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0] D,
  input  logic [ENC_W-1:0] ptr,
  input  logic             rr,
  output logic [ENC_W-1:0] winner,
  output logic             any
);

  logic [ENC_N-1:0]   req;
  logic [ENC_W-1:0]   base;
  logic [2*ENC_N-1:0] dbl;
  logic [ENC_N-1:0]   rot;
  logic [ENC_W-1:0]   idx;
  logic [ENC_W-1:0]   pick;

  // Fixed mode reuses the lowest-first search on bit-reversed requests; ~pick undoes the reversal.
  always_comb begin
    req  = rr ? D : {D[0], D[1], D[2], D[3]};
    base = rr ? ptr : '0;
    dbl  = {req, req};
    rot  = dbl[base +: ENC_N];
    idx  = '0;
    for (int i = ENC_N - 1; i >= 0; i--) begin
      if (rot[i]) idx = i[ENC_W-1:0];
    end
    pick   = idx + base;
    winner = rr ? pick : ~pick;
    any    = |D;
  end

endmodule

// File: rtl/encoder4x2_rr.sv
// rtl/encoder4x2_rr.sv - registered 4-to-2 encoder with valid/ack hold and fixed or round-robin priority
module encoder4x2_rr
  import enc_pkg::*;
#(
  parameter bit RR = ENC_RR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [ENC_N-1:0] D,
  input  logic             ack,
  output logic             A,
  output logic             B,
  output logic             V,
  output logic             Z
);

  enc_state_e       state_q, state_d;
  logic [ENC_W-1:0] code_q, code_d;
  logic [ENC_W-1:0] ptr_q, ptr_d;
  logic             z_q, z_d;
  logic [ENC_W-1:0] winner;
  logic             any;
  logic             slot_free;
  logic             cap;

  pri_sel4 u_sel (
    .D      (D),
    .ptr    (ptr_q),
    .rr     (RR),
    .winner (winner),
    .any    (any)
  );

  assign slot_free = (state_q == S_IDLE) || ack;
  assign cap       = e && any && slot_free;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    z_d     = z_q;

    case (state_q)
      S_IDLE: begin
        if (cap) begin
          code_d  = winner;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // ack without a new capture releases the slot but leaves the old code visible
        if (ack) begin
          if (cap) code_d = winner;
          else     state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (e && slot_free) z_d = !any;
    if (cap && (RR == ENC_RR)) ptr_d = winner + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      ptr_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      z_q     <= z_d;
    end
  end

  assign A = code_q[1];
  assign B = code_q[0];
  assign V = (state_q == S_HOLD);
  assign Z = z_q;

endmodule

// File: tb/tb_encoder4x2_rr.sv
// tb/tb_encoder4x2_rr.sv - scoreboard bench for encoder4x2_rr in fixed and round-robin builds
module tb_encoder4x2_rr;

  logic       clk = 1'b0;
  logic       rst, e, ack;
  logic [3:0] D;
  logic       fa, fb, fv, fz;
  logic       ra, rb, rv, rz;

  int errors = 0;
  int checks = 0;

  logic [1:0] q_fix[$];
  logic [1:0] q_rr[$];

  logic       f_hold = 1'b0, r_hold = 1'b0;
  logic [2:0] f_hold_val = '0, r_hold_val = '0;

  always #5 clk = ~clk;

  encoder4x2_rr #(.RR(1'b0)) u_fix (
    .clk (clk), .rst (rst), .e (e), .D (D), .ack (ack),
    .A (fa), .B (fb), .V (fv), .Z (fz)
  );

  encoder4x2_rr #(.RR(1'b1)) u_rr (
    .clk (clk), .rst (rst), .e (e), .D (D), .ack (ack),
    .A (ra), .B (rb), .V (rv), .Z (rz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dec2x4(input logic a, input logic b, input logic en);
    logic [1:0] c;
    c = {a, b};
    return en ? (4'b0001 << c) : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] f, input logic [1:0] r);
    q_fix.push_back(f);
    q_rr.push_back(r);
  endtask

  // A code is consumed on the edge following a sample with V=1 and ack=1.
  always @(negedge clk) begin
    if (fv === 1'b1 && ack === 1'b1) begin
      if (q_fix.size() == 0) chk("fix_unexpected_code", {fa, fb}, 32'hdead);
      else                   chk("fix_code", {fa, fb}, q_fix.pop_front());
    end
    if (rv === 1'b1 && ack === 1'b1) begin
      if (q_rr.size() == 0) chk("rr_unexpected_code", {ra, rb}, 32'hdead);
      else                  chk("rr_code", {ra, rb}, q_rr.pop_front());
    end
    if (f_hold) chk("fix_stable", {fa, fb, fv}, f_hold_val);
    if (r_hold) chk("rr_stable", {ra, rb, rv}, r_hold_val);
    f_hold     <= (fv === 1'b1) && (ack === 1'b0) && (rst === 1'b0);
    r_hold     <= (rv === 1'b1) && (ack === 1'b0) && (rst === 1'b0);
    f_hold_val <= {fa, fb, fv};
    r_hold_val <= {ra, rb, rv};
  end

  initial begin
    rst = 1'b1; e = 1'b1; D = 4'b1111; ack = 1'b0;
    repeat (2) begin
      tick();
      chk("rst_fix_outs", {fa, fb, fv, fz}, 4'b0000);
      chk("rst_rr_outs",  {ra, rb, rv, rz}, 4'b0000);
    end

    rst = 1'b0; e = 1'b0;
    repeat (2) begin
      tick();
      chk("idle_fix_v", fv, 1'b0);
      chk("idle_rr_v",  rv, 1'b0);
    end

    e = 1'b1; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = 4'b0001 << i;
      push(i[1:0], i[1:0]);
      tick();
      chk("rt_fix_v",   fv, 1'b1);
      chk("rt_fix_dec", dec2x4(fa, fb, 1'b1), D);
      chk("rt_rr_v",    rv, 1'b1);
      chk("rt_rr_dec",  dec2x4(ra, rb, 1'b1), D);
    end
    D = 4'b0000;
    tick();
    chk("rt_end_fix_vz", {fv, fz}, 2'b01);
    chk("rt_end_rr_vz",  {rv, rz}, 2'b01);

    ack = 1'b0; D = 4'b0100;
    push(2'd2, 2'd2);
    tick();
    D = 4'b1000;
    repeat (5) tick();
    chk("hold_fix", {fa, fb, fv}, 3'b101);
    chk("hold_rr",  {ra, rb, rv}, 3'b101);
    D = 4'b0000; ack = 1'b1;
    tick();
    chk("release_fix_vz", {fv, fz}, 2'b01);
    chk("release_rr_vz",  {rv, rz}, 2'b01);

    // rr pointer is 3 here after granting index 2
    D = 4'b1111;
    push(2'd3, 2'd3); tick();
    push(2'd3, 2'd0); tick();
    D = 4'b0110;
    push(2'd2, 2'd1); tick();
    D = 4'b0000;
    tick();
    chk("pri_end_fix_v", fv, 1'b0);
    chk("pri_end_rr_v",  rv, 1'b0);

    rst = 1'b1; D = 4'b1111; ack = 1'b1;
    tick();
    chk("rst2_fix_outs", {fa, fb, fv, fz}, 4'b0000);
    chk("rst2_rr_outs",  {ra, rb, rv, rz}, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(2'd3, i[1:0] & 2'b11);
      tick();
    end
    D = 4'b1001;
    push(2'd3, 2'd3); tick();
    push(2'd3, 2'd0); tick();
    D = 4'b0000;
    tick();
    chk("rr_end_fix_v", fv, 1'b0);
    chk("rr_end_rr_v",  rv, 1'b0);

    e = 1'b0; D = 4'b0101; ack = 1'b1;
    repeat (2) tick();
    chk("idle_ack_fix", {fa, fb, fv, fz}, 4'b1101);
    chk("idle_ack_rr",  {ra, rb, rv, rz}, 4'b0001);

    e = 1'b1; D = 4'b1000; ack = 1'b0;
    tick();
    chk("pre_rst_fix", {fa, fb, fv}, 3'b111);
    chk("pre_rst_rr",  {ra, rb, rv}, 3'b111);
    tick();
    rst = 1'b1;
    tick();
    chk("midhold_rst_fix", {fa, fb, fv, fz}, 4'b0000);
    chk("midhold_rst_rr",  {ra, rb, rv, rz}, 4'b0000);
    rst = 1'b0; D = 4'b1111; ack = 1'b1;
    push(2'd3, 2'd0);
    tick();
    chk("post_rst_rr_v", rv, 1'b1);
    D = 4'b0000;
    tick();

    // leave the rr pointer at 1, then check reset returns it to 0
    D = 4'b0001; ack = 1'b0;
    tick();
    chk("ptr_cap_rr", {ra, rb, rv}, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0; D = 4'b1111; ack = 1'b1;
    push(2'd3, 2'd0);
    tick();
    D = 4'b0000;
    repeat (2) tick();

    chk("fix_queue_drained", q_fix.size(), 0);
    chk("rr_queue_drained",  q_rr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
